// File: rtl/tx_shift_register.sv
// tx_shift_register: UART transmitter, 11 bit-time frames (start, 8 data LSB first, 2 stop).
// Define UART_TX_BREAK_EN to compile in break generation on send_break.
module tx_shift_register #(
  parameter int BREAK_BITS = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       send_break,
  output logic       sr_out,
  output logic       busy,
  output logic       tx_done,
  output logic       break_active,
  output logic       break_done
);
  typedef enum logic [2:0] {
    IDLE, PEND, START, DATA, STOP
`ifdef UART_TX_BREAK_EN
    , BRK_PEND, BREAK
`endif
  } state_t;
  localparam logic [7:0] BB = 8'(BREAK_BITS);
  state_t state, state_n;
  logic [7:0] shreg;
  logic [2:0] idx;
`ifdef UART_TX_BREAK_EN
  logic [7:0] cnt;
  logic brk_seq;
  assign tx_ready = (state == IDLE) && !send_break;
`else
  logic unused_cfg;
  assign unused_cfg = ^{send_break, BB};
  assign tx_ready = state == IDLE;
  assign break_active = 1'b0;
  assign break_done = 1'b0;
`endif
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) state_n = PEND;
`ifdef UART_TX_BREAK_EN
        if (send_break) state_n = BRK_PEND;
`endif
      end
      PEND:  state_n = baud_tick ? START : PEND;
      START: state_n = baud_tick ? DATA : START;
      DATA:  state_n = baud_tick && idx == 3'd7 ? STOP : DATA;
      STOP:  state_n = baud_tick ? IDLE : STOP;
`ifdef UART_TX_BREAK_EN
      BRK_PEND: state_n = baud_tick ? BREAK : BRK_PEND;
      BREAK:    state_n = baud_tick && cnt >= BB && !send_break ? STOP : BREAK;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr_out <= 1'b1;
      tx_done <= 1'b0;
      shreg <= '0;
      idx <= '0;
`ifdef UART_TX_BREAK_EN
      cnt <= '0;
      brk_seq <= 1'b0;
      break_active <= 1'b0;
      break_done <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tx_done <= 1'b0;
`ifdef UART_TX_BREAK_EN
      break_done <= 1'b0;
`endif
      if (state == IDLE && state_n == PEND) shreg <= tx_data;
      if (baud_tick) begin
        case (state)
          PEND: sr_out <= 1'b0;
          START: begin
            sr_out <= shreg[0];
            shreg <= shreg >> 1;
            idx <= '0;
          end
          DATA: begin
            if (idx == 3'd7) sr_out <= 1'b1;
            else begin
              sr_out <= shreg[0];
              shreg <= shreg >> 1;
              idx <= idx + 3'd1;
            end
          end
`ifdef UART_TX_BREAK_EN
          STOP: begin
            tx_done <= !brk_seq;
            break_done <= brk_seq;
            brk_seq <= 1'b0;
          end
          BRK_PEND: begin
            sr_out <= 1'b0;
            break_active <= 1'b1;
            brk_seq <= 1'b1;
            cnt <= 8'd1;
          end
          BREAK: begin
            if (state_n == STOP) begin
              sr_out <= 1'b1;
              break_active <= 1'b0;
            end else if (cnt != BB) cnt <= cnt + 8'd1;
          end
`else
          STOP: tx_done <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tx_shift_register.sv
// tb_tx_shift_register: directed checks of framing, back-to-back, reset abort and break handling.
module tb_tx_shift_register;
  logic clk = 0, rst = 1, baud_tick = 0, tx_valid = 0, send_break = 0;
  logic [7:0] tx_data = '0;
  logic tx_ready, sr_out, busy, tx_done, break_active, break_done;
  logic [10:0] f3c;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tx_shift_register dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .send_break(send_break), .sr_out(sr_out), .busy(busy),
    .tx_done(tx_done), .break_active(break_active), .break_done(break_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    repeat (15) clk1();
    baud_tick = 1;
    clk1();
    baud_tick = 0;
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {2'b11, d, 1'b0};
  endfunction
  task automatic run_frame(input string nm, input logic [10:0] exp);
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("%s_bit%0d", nm, k), sr_out, exp[k]);
      check($sformatf("%s_done%0d", nm, k), tx_done, k == 10);
    end
  endtask
  initial begin
    baud_tick = 1;
    repeat (3) clk1();
    rst = 0;
    baud_tick = 0;
    check("rst_sr_out", sr_out, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_break_active", break_active, 0);
    check("rst_break_done", break_done, 0);
    check("rst_tx_ready", tx_ready, 1);
    tx_data = 8'hA5;
    tx_valid = 1;
    clk1();
    tx_valid = 0;
    tx_data = 8'h00;
    check("a5_accept_busy", busy, 1);
    check("a5_accept_ready", tx_ready, 0);
    repeat (5) clk1();
    check("a5_pend_line", sr_out, 1);
    run_frame("a5", 11'b11101001010);
    check("a5_end_busy", busy, 0);
    clk1();
    check("a5_done_pulse", tx_done, 0);
    tx_data = 8'h00;
    tx_valid = 1;
    clk1();
    tx_data = 8'hFF;
    check("b2b_busy0", busy, 1);
    run_frame("x00", frame_of(8'h00));
    check("b2b_gap_ready", tx_ready, 1);
    clk1();
    check("b2b_reaccept_ready", tx_ready, 0);
    check("b2b_reaccept_busy", busy, 1);
    tx_valid = 0;
    run_frame("xff", frame_of(8'hFF));
    check("b2b_end_busy", busy, 0);
    f3c = frame_of(8'h3C);
    tx_data = 8'h3C;
    tx_valid = 1;
    clk1();
    tx_valid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("x3c_bit%0d", k), sr_out, f3c[k]);
    end
    repeat (5) clk1();
    rst = 1;
    baud_tick = 1;
    clk1();
    rst = 0;
    baud_tick = 0;
    check("abort_busy", busy, 0);
    check("abort_line", sr_out, 1);
    check("abort_ready", tx_ready, 1);
    check("abort_done", tx_done, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("abort_idle_line%0d", k), sr_out, 1);
      check($sformatf("abort_idle_done%0d", k), tx_done, 0);
    end
    tx_data = 8'h81;
    tx_valid = 1;
    clk1();
    tx_valid = 0;
    run_frame("x81", frame_of(8'h81));
`ifdef UART_TX_BREAK_EN
    send_break = 1;
    tx_valid = 1;
    tx_data = 8'h55;
    #1;
    check("brk_ready_low", tx_ready, 0);
    clk1();
    send_break = 0;
    tx_valid = 0;
    check("brk_pend_busy", busy, 1);
    check("brk_pend_line", sr_out, 1);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check($sformatf("brk1_line%0d", k), sr_out, k > 22);
      check($sformatf("brk1_active%0d", k), break_active, k <= 22);
      check($sformatf("brk1_done%0d", k), break_done, k == 24);
      check($sformatf("brk1_txdone%0d", k), tx_done, 0);
    end
    check("brk1_end_busy", busy, 0);
    send_break = 1;
    clk1();
    for (int k = 1; k <= 32; k++) begin
      tick();
      check($sformatf("brk30_line%0d", k), sr_out, k > 30);
      check($sformatf("brk30_active%0d", k), break_active, k <= 30);
      check($sformatf("brk30_done%0d", k), break_done, k == 32);
      if (k == 30) send_break = 0;
    end
    check("brk30_end_busy", busy, 0);
`else
    send_break = 1;
    #1;
    check("nobrk_ready", tx_ready, 1);
    clk1();
    send_break = 0;
    check("nobrk_busy", busy, 0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check($sformatf("nobrk_line%0d", k), sr_out, 1);
      check($sformatf("nobrk_done%0d", k), break_done, 0);
      check($sformatf("nobrk_active%0d", k), break_active, 0);
    end
    send_break = 1;
    tx_data = 8'h5A;
    tx_valid = 1;
    clk1();
    tx_valid = 0;
    check("nobrk_accept", busy, 1);
    run_frame("x5a", frame_of(8'h5A));
    send_break = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
